// File: rtl/calc_g_scan_ctrl_pkg.sv
// Shared types for the calc_G sweep sequencer, calc_G_top and downstream consumers:
// index/zparam widths, sweep FSM encoding and the sideband tag record.
package calc_g_scan_ctrl_pkg;

  localparam int IDX_W = 10;
  localparam int Z_W   = 32;

  typedef logic signed [IDX_W-1:0] idx_t;
  typedef logic [Z_W-1:0]          zparam_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  // Sideband travelling alongside calc_G_top's datapath.
  typedef struct packed {
    logic valid;
    logic last;
    idx_t m;
    idx_t n;
  } tag_t;

endpackage

// File: rtl/calc_g_scan_ctrl_if.sv
// Host-side control/range bus plus calc_G_top-facing index and tag outputs.
// The master modport is the host/config side; the slave modport is the sequencer.
interface calc_g_scan_ctrl_if;
  import calc_g_scan_ctrl_pkg::*;

  logic    start;
  logic    abort;
  idx_t    m_min;
  idx_t    m_max;
  idx_t    n_min;
  idx_t    n_max;
  zparam_t zparam_in;

  idx_t    m;
  idx_t    n;
  zparam_t zparam;
  logic    g_valid;
  idx_t    g_m;
  idx_t    g_n;
  logic    g_last;
  logic    busy;
  logic    done;
  logic    range_err;

  modport master (
    output start, abort, m_min, m_max, n_min, n_max, zparam_in,
    input  m, n, zparam, g_valid, g_m, g_n, g_last, busy, done, range_err
  );

  modport slave (
    input  start, abort, m_min, m_max, n_min, n_max, zparam_in,
    output m, n, zparam, g_valid, g_m, g_n, g_last, busy, done, range_err
  );

endinterface

// File: rtl/calc_g_tag_pipe.sv
// DEPTH-stage shift register of sweep tags, matched to calc_G_top latency.
// i_clear drops valid/last in every stage (including the one being loaded).
module calc_g_tag_pipe
  import calc_g_scan_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [DEPTH];

  // NOTE: the whole array is reset, not only the valid bits, because the tail
  // drives g_m/g_n directly and those must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_stage[i].valid <= 1'b0;
          r_stage[i].last  <= 1'b0;
        end
      end
    end
  end

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/calc_g_scan_ctrl.sv
// Sweeps the signed (m,n) grid one point per clock into calc_G_top and carries
// a latency-matched {valid,last,m,n} tag so results arrive with their indices.
module calc_g_scan_ctrl
  import calc_g_scan_ctrl_pkg::*;
#(
  parameter int G_LATENCY = 8
) (
  input logic               clk,
  input logic               rst_n,
  calc_g_scan_ctrl_if.slave bus
);

  state_t  r_state;
  state_t  w_state_nxt;
  idx_t    r_m;
  idx_t    r_n;
  idx_t    r_m_max;
  idx_t    r_n_min;
  idx_t    r_n_max;
  zparam_t r_zparam;
  logic    r_done;
  logic    r_range_err;

  logic    w_range_ok;
  logic    w_accept;
  logic    w_reject;
  logic    w_issue;
  logic    w_at_end;
  logic    w_done;
  tag_t    w_tag_in;
  tag_t    w_tail;

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path holds its old value,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_issue     = 1'b0;
    w_at_end    = 1'b0;
    w_done      = 1'b0;
    w_range_ok  = (bus.m_min <= bus.m_max) && (bus.n_min <= bus.n_max);
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (w_range_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        w_issue  = 1'b1;
        w_at_end = (r_m == r_m_max) && (r_n == r_n_max);
        if (w_at_end) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_tail.valid && w_tail.last) begin
          w_done      = !bus.abort;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.abort) w_state_nxt = ST_IDLE;
    w_tag_in = '{valid: w_issue, last: w_at_end, m: r_m, n: r_n};
  end

  // Counters compare against the bound before stepping, so -512..511 never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m         <= '0;
      r_n         <= '0;
      r_m_max     <= '0;
      r_n_min     <= '0;
      r_n_max     <= '0;
      r_zparam    <= '0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_done      <= w_done;
      r_range_err <= w_reject;
      if (w_accept) begin
        r_m      <= bus.m_min;
        r_n      <= bus.n_min;
        r_m_max  <= bus.m_max;
        r_n_min  <= bus.n_min;
        r_n_max  <= bus.n_max;
        r_zparam <= bus.zparam_in;
      end else if (w_issue && !w_at_end && !bus.abort) begin
        if (r_n == r_n_max) begin
          r_n <= r_n_min;
          r_m <= r_m + idx_t'(1);
        end else begin
          r_n <= r_n + idx_t'(1);
        end
      end
    end
  end

  calc_g_tag_pipe #(.DEPTH(G_LATENCY)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (bus.abort),
    .i_tag   (w_tag_in),
    .o_tag   (w_tail)
  );

  assign bus.m         = r_m;
  assign bus.n         = r_n;
  assign bus.zparam    = r_zparam;
  assign bus.g_valid   = w_tail.valid;
  assign bus.g_m       = w_tail.m;
  assign bus.g_n       = w_tail.n;
  assign bus.g_last    = w_tail.valid & w_tail.last;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.range_err = r_range_err;

endmodule

// File: tb/tb_calc_g_scan_ctrl.sv
// Self-checking bench for calc_g_scan_ctrl: vector table, hand-written abort and
// restart sequences, and randomized ranges against a nested-loop grid model.
module tb_calc_g_scan_ctrl;
  import calc_g_scan_ctrl_pkg::*;

  localparam int L = 8;

  typedef struct {
    int      m_min;
    int      m_max;
    int      n_min;
    int      n_max;
    zparam_t z;
    int      exp_pts;
    bit      exp_err;
  } vec_t;

  typedef struct {
    int m;
    int n;
  } pt_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  vec_t vecs [8];

  calc_g_scan_ctrl_if bus ();

  calc_g_scan_ctrl #(.G_LATENCY(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_range(input int mlo, input int mhi, input int nlo, input int nhi,
                             input zparam_t z);
    bus.m_min     = idx_t'(mlo);
    bus.m_max     = idx_t'(mhi);
    bus.n_min     = idx_t'(nlo);
    bus.n_max     = idx_t'(nhi);
    bus.zparam_in = z;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_sweep(input int mlo, input int mhi, input int nlo, input int nhi,
                           input zparam_t z, input int exp_pts, input bit exp_err,
                           input int restart_at, input string tag);
    pt_t     q[$];
    idx_t    m_prev;
    idx_t    n_prev;
    zparam_t z_prev;
    int      seen;
    int      np;
    for (int mi = mlo; mi <= mhi; mi++)
      for (int ni = nlo; ni <= nhi; ni++)
        q.push_back('{m: mi, n: ni});
    np     = q.size();
    m_prev = bus.m;
    n_prev = bus.n;
    z_prev = bus.zparam;
    seen   = 0;
    drive_range(mlo, mhi, nlo, nhi, z);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (exp_err) begin
      check({tag, " range_err"}, bus.range_err, 1);
      for (int t = 0; t <= L + 3; t++) begin
        check($sformatf("%s t%0d busy", tag, t), bus.busy, 0);
        check($sformatf("%s t%0d g_valid", tag, t), bus.g_valid, 0);
        check($sformatf("%s t%0d done", tag, t), bus.done, 0);
        check($sformatf("%s t%0d m held", tag, t), bus.m, m_prev);
        check($sformatf("%s t%0d n held", tag, t), bus.n, n_prev);
        check($sformatf("%s t%0d zparam held", tag, t), bus.zparam, z_prev);
        if (t > 0) check($sformatf("%s t%0d range_err low", tag, t), bus.range_err, 0);
        @(negedge clk);
      end
    end else begin
      for (int t = 0; t <= np + L + 3; t++) begin
        if (t < np) begin
          check($sformatf("%s t%0d m", tag, t), bus.m, q[t].m);
          check($sformatf("%s t%0d n", tag, t), bus.n, q[t].n);
          check($sformatf("%s t%0d zparam", tag, t), bus.zparam, z);
        end
        check($sformatf("%s t%0d busy", tag, t), bus.busy, t < np + L);
        check($sformatf("%s t%0d done", tag, t), bus.done, t == np + L);
        check($sformatf("%s t%0d range_err", tag, t), bus.range_err, 0);
        check($sformatf("%s t%0d g_valid", tag, t), bus.g_valid, (t >= L) && (t < L + np));
        if ((t >= L) && (t < L + np)) begin
          check($sformatf("%s t%0d g_m", tag, t), bus.g_m, q[t-L].m);
          check($sformatf("%s t%0d g_n", tag, t), bus.g_n, q[t-L].n);
          check($sformatf("%s t%0d g_last", tag, t), bus.g_last, (t - L) == (np - 1));
        end
        if (bus.g_valid) seen++;
        if (t == restart_at) begin
          drive_range(5, 9, -7, 7, ~z);
          bus.start = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
      check({tag, " g_valid count"}, seen, exp_pts);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_range(0, 0, 0, 0, '0);

    vecs[0] = '{m_min:    1, m_max:    1, n_min:    1, n_max:    2, z: 32'h0000_1002, exp_pts: 2, exp_err: 1'b0};
    vecs[1] = '{m_min:   -1, m_max:    1, n_min:   -3, n_max:   -2, z: 32'h0004_D04D, exp_pts: 6, exp_err: 1'b0};
    vecs[2] = '{m_min:    2, m_max:    1, n_min:    0, n_max:    0, z: 32'h1234_5678, exp_pts: 0, exp_err: 1'b1};
    vecs[3] = '{m_min:    0, m_max:    0, n_min:    5, n_max:    5, z: 32'h0000_0ABC, exp_pts: 1, exp_err: 1'b0};
    vecs[4] = '{m_min:    1, m_max:   -1, n_min:    0, n_max:    0, z: 32'hDEAD_BEEF, exp_pts: 0, exp_err: 1'b1};
    vecs[5] = '{m_min:    0, m_max:    1, n_min:    3, n_max:    2, z: 32'h0BAD_F00D, exp_pts: 0, exp_err: 1'b1};
    vecs[6] = '{m_min:  511, m_max:  511, n_min:  508, n_max:  511, z: 32'hFFFF_F000, exp_pts: 4, exp_err: 1'b0};
    vecs[7] = '{m_min: -512, m_max: -511, n_min: -512, n_max: -510, z: 32'h0001_0001, exp_pts: 6, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check("rst m", bus.m, 0);
    check("rst n", bus.n, 0);
    check("rst zparam", bus.zparam, 0);
    check("rst g_valid", bus.g_valid, 0);
    check("rst g_m", bus.g_m, 0);
    check("rst g_n", bus.g_n, 0);
    check("rst g_last", bus.g_last, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst range_err", bus.range_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_sweep(vecs[i].m_min, vecs[i].m_max, vecs[i].n_min, vecs[i].n_max, vecs[i].z,
                vecs[i].exp_pts, vecs[i].exp_err, -1, $sformatf("vec%0d", i));

    // Abort on the third issue cycle of a 4x4 sweep, then rerun cleanly.
    drive_range(0, 3, 0, 3, 32'h0000_7777);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      check($sformatf("abort t%0d m", t), bus.m, 0);
      check($sformatf("abort t%0d n", t), bus.n, t);
      check($sformatf("abort t%0d busy", t), bus.busy, 1);
      if (t == 2) bus.abort = 1'b1;
      @(negedge clk);
    end
    bus.abort = 1'b0;
    for (int t = 0; t <= L + 3; t++) begin
      check($sformatf("post-abort t%0d busy", t), bus.busy, 0);
      check($sformatf("post-abort t%0d g_valid", t), bus.g_valid, 0);
      check($sformatf("post-abort t%0d done", t), bus.done, 0);
      @(negedge clk);
    end
    run_sweep(0, 3, 0, 3, 32'h0000_8888, 16, 1'b0, -1, "rerun");

    // Abort beats a simultaneous start, for both valid and invalid ranges.
    drive_range(0, 1, 0, 1, 32'h0000_0001);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    check("start+abort busy", bus.busy, 0);
    drive_range(3, 1, 0, 1, 32'h0000_0001);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start+abort range_err", bus.range_err, 0);
    check("start+abort busy2", bus.busy, 0);
    for (int t = 0; t <= L + 1; t++) begin
      check($sformatf("start+abort t%0d g_valid", t), bus.g_valid, 0);
      @(negedge clk);
    end

    // A second start mid-sweep with different ranges is ignored.
    run_sweep(0, 1, 0, 2, 32'h00AB_C123, 6, 1'b0, 2, "restart");

    for (int k = 0; k < 20; k++) begin
      int mlo, mhi, nlo, nhi, pts;
      bit err;
      mlo = int'($urandom_range(0, 1022)) - 512;
      nlo = int'($urandom_range(0, 1022)) - 512;
      mhi = mlo + int'($urandom_range(0, 3)) - (($urandom_range(0, 4) == 0) ? 4 : 0);
      nhi = nlo + int'($urandom_range(0, 3)) - (($urandom_range(0, 4) == 0) ? 4 : 0);
      if (mhi > 511) mhi = 511;
      if (nhi > 511) nhi = 511;
      if (mhi < -512) mhi = -512;
      if (nhi < -512) nhi = -512;
      err = (mlo > mhi) || (nlo > nhi);
      pts = err ? 0 : (mhi - mlo + 1) * (nhi - nlo + 1);
      run_sweep(mlo, mhi, nlo, nhi, $urandom, pts, err, -1, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
